// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle Mini-MIPS datapath.
// Moore-decoded controls; FETCH/MEMWR gate strobes on mem_ready.
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   is_lw_q, is_lw_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    is_lw_d     = is_lw_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state       = reset ? 4'd0 : state_q;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        is_lw_d = (opcode == OP_LW);
        if (opcode == OP_LW || opcode == OP_SW)
          state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)
          state_d = S_EXEC;
        else if (opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if (opcode == OP_J)
          state_d = S_JUMP;
        else if (opcode == OP_ADDI)
          state_d = S_ADDIEX;
        else
          illegal_op = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must mask every strobe in the same cycle, even mid-stall.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control.
// Checks state and the full control vector every cycle.
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic       instr_done, illegal_op;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst,instr_done,illegal_op}
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                 MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcA,
                 ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};

  localparam logic [17:0] O_ZERO   = 18'b0000000_00_00_0_00_0000;
  localparam logic [17:0] O_F_RDY  = 18'b1001001_00_00_0_01_0000;
  localparam logic [17:0] O_F_STL  = 18'b0001000_00_00_0_01_0000;
  localparam logic [17:0] O_DEC    = 18'b0000000_00_00_0_11_0000;
  localparam logic [17:0] O_DEC_IL = 18'b0000000_00_00_0_11_0001;
  localparam logic [17:0] O_MEMADR = 18'b0000000_00_00_1_10_0000;
  localparam logic [17:0] O_MEMRD  = 18'b0011000_00_00_0_00_0000;
  localparam logic [17:0] O_MEMWB  = 18'b0000010_00_00_0_00_1010;
  localparam logic [17:0] O_WR_RDY = 18'b0010100_00_00_0_00_0010;
  localparam logic [17:0] O_WR_STL = 18'b0010100_00_00_0_00_0000;
  localparam logic [17:0] O_EXEC   = 18'b0000000_00_10_1_00_0000;
  localparam logic [17:0] O_RTWB   = 18'b0000000_00_00_0_00_1110;
  localparam logic [17:0] O_BRANCH = 18'b0100000_01_01_1_00_0010;
  localparam logic [17:0] O_JUMP   = 18'b1000000_10_00_0_00_0010;
  localparam logic [17:0] O_ADDIWB = 18'b0000000_00_00_0_00_1010;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [17:0] obs,
                     input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next edge.
  task automatic run(input logic [3:0] es, input logic [17:0] eo,
                     input string tag);
    @(negedge clk);
    chk({tag, "_state"}, {14'd0, state}, {14'd0, es});
    chk({tag, "_outs"}, outs, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    @(posedge clk);
    #1;
    run(4'd0, O_ZERO, "reset");
    reset = 1'b0;

    // R-type: 0,1,6,7
    run(4'd0, O_F_RDY, "r_fetch");
    run(4'd1, O_DEC, "r_dec");
    run(4'd6, O_EXEC, "r_exec");
    run(4'd7, O_RTWB, "r_rtwb");

    // LW with 2 stall cycles; opcode change after decode is ignored
    opcode = 6'b100011;
    run(4'd0, O_F_RDY, "lw_fetch");
    run(4'd1, O_DEC, "lw_dec");
    opcode = 6'b101011;
    run(4'd2, O_MEMADR, "lw_memadr");
    mem_ready = 1'b0;
    run(4'd3, O_MEMRD, "lw_memrd0");
    run(4'd3, O_MEMRD, "lw_memrd1");
    mem_ready = 1'b1;
    run(4'd3, O_MEMRD, "lw_memrd2");
    run(4'd4, O_MEMWB, "lw_memwb");

    // SW, no stall
    opcode = 6'b101011;
    run(4'd0, O_F_RDY, "sw_fetch");
    run(4'd1, O_DEC, "sw_dec");
    run(4'd2, O_MEMADR, "sw_memadr");
    run(4'd5, O_WR_RDY, "sw_memwr");

    // SW with one stall in MEMWR
    run(4'd0, O_F_RDY, "sw2_fetch");
    run(4'd1, O_DEC, "sw2_dec");
    run(4'd2, O_MEMADR, "sw2_memadr");
    mem_ready = 1'b0;
    run(4'd5, O_WR_STL, "sw2_memwr_stall");
    mem_ready = 1'b1;
    run(4'd5, O_WR_RDY, "sw2_memwr");

    // BEQ
    opcode = 6'b000100;
    run(4'd0, O_F_RDY, "beq_fetch");
    run(4'd1, O_DEC, "beq_dec");
    run(4'd8, O_BRANCH, "beq_branch");

    // J
    opcode = 6'b000010;
    run(4'd0, O_F_RDY, "j_fetch");
    run(4'd1, O_DEC, "j_dec");
    run(4'd9, O_JUMP, "j_jump");

    // Illegal opcode
    opcode = 6'b111111;
    run(4'd0, O_F_RDY, "ill_fetch");
    run(4'd1, O_DEC_IL, "ill_dec");

    // ADDI
    opcode = 6'b001000;
    run(4'd0, O_F_RDY, "addi_fetch");
    run(4'd1, O_DEC, "addi_dec");
    run(4'd10, O_MEMADR, "addi_ex");
    run(4'd11, O_ADDIWB, "addi_wb");

    // Reset during MEMRD stall, then stalled fetch
    opcode = 6'b100011;
    run(4'd0, O_F_RDY, "rst_fetch");
    run(4'd1, O_DEC, "rst_dec");
    run(4'd2, O_MEMADR, "rst_memadr");
    mem_ready = 1'b0;
    run(4'd3, O_MEMRD, "rst_memrd");
    reset = 1'b1;
    run(4'd0, O_ZERO, "rst_mid");
    reset = 1'b0;
    run(4'd0, O_F_STL, "fstall0");
    run(4'd0, O_F_STL, "fstall1");
    run(4'd0, O_F_STL, "fstall2");
    mem_ready = 1'b1;
    opcode = 6'b000000;
    run(4'd0, O_F_RDY, "post_fetch");
    run(4'd1, O_DEC, "post_dec");
    run(4'd6, O_EXEC, "post_exec");
    run(4'd7, O_RTWB, "post_rtwb");
    run(4'd0, O_F_RDY, "post_fetch2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
